// File: rtl/credit_display_mux.sv
// credit_display_mux
//
// Multiplexed seven-segment credit display. A loaded credit target is either
// shown at once or counted up to one step at a time. The shown value goes
// through a sequential double-dabble binary-to-BCD engine, and the digits are
// scanned with leading-zero blanking and a blank gap at the start of each slot.
//
// Ports:
//   clk                  - system clock
//   reset_n              - asynchronous active-low reset
//   load_valid           - single-cycle strobe that loads a new target
//   load_value           - new credit target, sampled with load_valid
//   busy                 - high while the shown value is counting toward target
//   select               - one-hot digit enable (polarity per SEL_ACTIVE_LOW)
//   seven_segment_output - segments {g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
//
// Parameter legality: 10**NUM_DIGITS > 2**VALUE_WIDTH, VALUE_WIDTH >= 2,
// REFRESH_DIV >= 2, BLANK_CYCLES < REFRESH_DIV, STEP_DIV >= 1.

module credit_display_mux #(
    parameter int unsigned VALUE_WIDTH    = 12,
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter int unsigned STEP_DIV       = 250000,
    parameter int unsigned ANIMATE        = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned SEL_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_valid,
    input  logic [VALUE_WIDTH-1:0] load_value,
    output logic                   busy,
    output logic [NUM_DIGITS-1:0]  select,
    output logic [6:0]             seven_segment_output
);

    localparam int unsigned BcdW  = 4 * NUM_DIGITS;
    localparam int unsigned StepW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned CntW  = $clog2(VALUE_WIDTH + 1);
    localparam int unsigned SlotW = $clog2(REFRESH_DIV);
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [StepW-1:0] StepLast = StepW'(STEP_DIV - 1);
    localparam logic [SlotW-1:0] SlotLast = SlotW'(REFRESH_DIV - 1);
    localparam logic [SlotW-1:0] SlotShow = SlotW'(BLANK_CYCLES);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] SelOff =
        (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0] SegOff = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    // Active-high segment pattern for one BCD digit; 10..15 never occur and
    // decode to all-off.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Target / shown value and count-up animation
    // ------------------------------------------------------------------
    logic [VALUE_WIDTH-1:0] target_q;
    logic [VALUE_WIDTH-1:0] disp_val_q;
    logic [VALUE_WIDTH-1:0] disp_inc;
    logic [StepW-1:0]       step_cnt_q;
    logic                   busy_q;

    assign disp_inc = disp_val_q + VALUE_WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q   <= '0;
            disp_val_q <= '0;
            step_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else if (load_valid) begin
            target_q   <= load_value;
            step_cnt_q <= '0;
            // Decreases (and equal values) are never animated.
            if (ANIMATE == 0 || load_value <= disp_val_q) begin
                disp_val_q <= load_value;
                busy_q     <= 1'b0;
            end else begin
                busy_q <= 1'b1;
            end
        end else if (disp_val_q < target_q) begin
            if (step_cnt_q == StepLast) begin
                step_cnt_q <= '0;
                disp_val_q <= disp_inc;
                // busy drops on the same edge the shown value reaches target.
                busy_q     <= (disp_inc != target_q);
            end else begin
                step_cnt_q <= step_cnt_q + StepW'(1);
            end
        end
    end

    assign busy = busy_q;

    // ------------------------------------------------------------------
    // Sequential double-dabble conversion
    // ------------------------------------------------------------------
    typedef enum logic {StIdle, StConv} conv_state_e;

    conv_state_e            state_q;
    logic [VALUE_WIDTH-1:0] shift_q;
    logic [VALUE_WIDTH-1:0] cap_q;
    logic [VALUE_WIDTH-1:0] last_conv_q;
    logic [BcdW-1:0]        acc_q;
    logic [BcdW-1:0]        bcd_q;
    logic [CntW-1:0]        cnt_q;

    logic [BcdW-1:0]        acc_adj;
    logic [BcdW-1:0]        acc_next;
    logic [VALUE_WIDTH-1:0] shift_next;

    // One iteration: add 3 to every nibble >= 5, then shift the value MSB in.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_next   = {acc_adj[BcdW-2:0], shift_q[VALUE_WIDTH-1]};
        shift_next = {shift_q[VALUE_WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            cap_q       <= '0;
            last_conv_q <= '0;
            acc_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (disp_val_q != last_conv_q) begin
                        shift_q <= disp_val_q;
                        cap_q   <= disp_val_q;
                        acc_q   <= '0;
                        cnt_q   <= CntW'(VALUE_WIDTH);
                        state_q <= StConv;
                    end
                end
                StConv: begin
                    acc_q   <= acc_next;
                    shift_q <= shift_next;
                    cnt_q   <= cnt_q - CntW'(1);
                    // bcd is only written with a finished conversion; a value
                    // change mid-conversion is picked up again from StIdle.
                    if (cnt_q == CntW'(1)) begin
                        bcd_q       <= acc_next;
                        last_conv_q <= cap_q;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    logic [SlotW-1:0]      slot_q;
    logic [SlotW-1:0]      slot_d;
    logic [IdxW-1:0]       idx_q;
    logic [IdxW-1:0]       idx_d;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  all_zero;
    logic [3:0]            nibble;
    logic [NUM_DIGITS-1:0] sel_on;
    logic [6:0]            seg_on;
    logic [NUM_DIGITS-1:0] sel_q;
    logic [6:0]            seg_q;

    always_comb begin
        slot_d = slot_q + SlotW'(1);
        idx_d  = idx_q;
        if (slot_q == SlotLast) begin
            slot_d = '0;
            idx_d  = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end
    end

    // lead_zero[i]: digit i and every digit above it are zero.
    always_comb begin
        all_zero  = 1'b1;
        lead_zero = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            all_zero     = all_zero && (bcd_q[4*i +: 4] == 4'd0);
            lead_zero[i] = all_zero;
        end
    end

    // Output registers are loaded from the next slot/index so they line up
    // with the counters they describe.
    always_comb begin
        nibble = bcd_q[{idx_d, 2'b00} +: 4];
        sel_on = '0;
        seg_on = 7'h00;
        if (slot_d >= SlotShow) begin
            sel_on[idx_d] = 1'b1;
            if (idx_d == '0 || !lead_zero[idx_d]) begin
                seg_on = seg_decode(nibble);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= '0;
            idx_q  <= '0;
            sel_q  <= SelOff;
            seg_q  <= SegOff;
        end else begin
            slot_q <= slot_d;
            idx_q  <= idx_d;
            sel_q  <= (SEL_ACTIVE_LOW != 0) ? ~sel_on : sel_on;
            seg_q  <= (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        end
    end

    assign select               = sel_q;
    assign seven_segment_output = seg_q;

endmodule

// File: tb/tb_credit_display_mux.sv
// Bench for credit_display_mux: dut0 jumps (ANIMATE=0), dut1 counts up.
module tb_credit_display_mux;

    localparam int unsigned VW = 12;
    localparam int unsigned ND = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;
    localparam int unsigned SD = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load_valid0, load_valid1;
    logic [VW-1:0] load_value0, load_value1;
    logic          busy0, busy1;
    logic [ND-1:0] select0, select1;
    logic [6:0]    seg0, seg1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ph = 0;

    typedef struct {
        int    due;
        int    kind;
        int    exp;
        string tag;
    } exp_t;
    exp_t sb[$];

    credit_display_mux #(
        .VALUE_WIDTH(VW), .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC),
        .STEP_DIV(SD), .ANIMATE(0), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .load_valid(load_valid0), .load_value(load_value0),
        .busy(busy0), .select(select0), .seven_segment_output(seg0)
    );

    credit_display_mux #(
        .VALUE_WIDTH(VW), .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC),
        .STEP_DIV(SD), .ANIMATE(1), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .load_valid(load_valid1), .load_value(load_value1),
        .busy(busy1), .select(select1), .seven_segment_output(seg1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Edges since reset release; slot = ph % RD, digit = (ph / RD) % ND.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ph <= 0;
        else          ph <= ph + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int to_bcd(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < int'(ND); i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    // Expected active-low outputs for shown value v at phase p.
    function automatic void exp_scan(input int v, input int p,
                                     output logic [3:0] sel, output logic [6:0] seg);
        int slot, idx, scale;
        sel = 4'hF;
        seg = 7'h7F;
        if (p == 0) return;
        slot = p % int'(RD);
        idx  = (p / int'(RD)) % int'(ND);
        if (slot < int'(BC)) return;
        scale = 1;
        for (int k = 0; k < idx; k++) scale = scale * 10;
        sel[idx] = 1'b0;
        if (idx > 0 && v < scale) seg = 7'h7F;
        else                      seg = ~pat((v / scale) % 10);
    endfunction

    function automatic int sample(input int kind);
        case (kind)
            0:       return int'(dut0.bcd_q);
            1:       return int'(dut1.disp_val_q);
            default: return int'(busy1);
        endcase
    endfunction

    task automatic expect_at(input int dly, input int kind, input int exp, input string tag);
        exp_t e;
        e.due  = cyc + dly;
        e.kind = kind;
        e.exp  = exp;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Scoreboard drain: compare every entry whose cycle has come.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                if (sb[i].due < cyc) check_eq({sb[i].tag, "_late"}, -1, sb[i].exp);
                else                 check_eq(sb[i].tag, sample(sb[i].kind), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load0(input int v);
        load_value0 = v[VW-1:0];
        load_valid0 = 1'b1;
        tick(1);
        load_valid0 = 1'b0;
    endtask

    task automatic load1(input int v);
        load_value1 = v[VW-1:0];
        load_valid1 = 1'b1;
        tick(1);
        load_valid1 = 1'b0;
    endtask

    task automatic scan_check(input string tag, input int v0, input int v1, input int n);
        logic [3:0] es;
        logic [6:0] eg;
        for (int i = 0; i < n; i++) begin
            tick(1);
            exp_scan(v0, ph, es, eg);
            check_eq({tag, "_sel0"}, int'(select0), int'(es));
            check_eq({tag, "_seg0"}, int'(seg0), int'(eg));
            exp_scan(v1, ph, es, eg);
            check_eq({tag, "_sel1"}, int'(select1), int'(es));
            check_eq({tag, "_seg1"}, int'(seg1), int'(eg));
        end
    endtask

    task automatic reset_outputs_check(input string tag);
        check_eq({tag, "_sel0"}, int'(select0), 'hF);
        check_eq({tag, "_seg0"}, int'(seg0), 'h7F);
        check_eq({tag, "_sel1"}, int'(select1), 'hF);
        check_eq({tag, "_seg1"}, int'(seg1), 'h7F);
        check_eq({tag, "_busy0"}, int'(busy0), 0);
        check_eq({tag, "_busy1"}, int'(busy1), 0);
        check_eq({tag, "_bcd0"}, int'(dut0.bcd_q), 0);
        check_eq({tag, "_disp1"}, int'(dut1.disp_val_q), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_n     = 1'b0;
        load_valid0 = 1'b0;
        load_valid1 = 1'b0;
        load_value0 = '0;
        load_value1 = '0;
        tick(3);
        reset_outputs_check("rst");
        reset_n = 1'b1;
        scan_check("zero", 0, 0, 32);

        // Jump mode: exact 14-cycle conversion latency.
        expect_at(13, 0, to_bcd(0), "bcd1234_pre");
        expect_at(14, 0, to_bcd(1234), "bcd1234");
        load0(1234);
        tick(20);
        scan_check("s1234", 1234, 0, 32);

        expect_at(13, 0, to_bcd(1234), "bcd4095_pre");
        expect_at(14, 0, to_bcd(4095), "bcd4095");
        load0(4095);
        tick(20);
        scan_check("s4095", 4095, 0, 32);

        expect_at(14, 0, to_bcd(7), "bcd7");
        load0(7);
        tick(20);
        scan_check("s7", 7, 0, 32);

        // Load 7 while 4095 is converting: 4095 lands whole, then 7.
        expect_at(13, 0, to_bcd(7), "mid_pre");
        expect_at(14, 0, to_bcd(4095), "mid_4095a");
        expect_at(26, 0, to_bcd(4095), "mid_4095b");
        expect_at(27, 0, to_bcd(7), "mid_7");
        load0(4095);
        tick(2);
        load0(7);
        tick(30);

        // Count-up mode.
        expect_at(1, 2, 1, "busy_up100");
        load1(100);
        n = 0;
        while (busy1 !== 1'b0 && n < 600) begin
            tick(1);
            n++;
        end
        check_eq("settle100", int'(dut1.disp_val_q), 100);

        expect_at(1, 2, 1, "b103_busy");
        expect_at(4, 1, 100, "d103_4");
        expect_at(5, 1, 101, "d103_5");
        expect_at(8, 1, 101, "d103_8");
        expect_at(9, 1, 102, "d103_9");
        expect_at(12, 1, 102, "d103_12");
        expect_at(12, 2, 1, "b103_12");
        expect_at(13, 1, 103, "d103_13");
        expect_at(13, 2, 0, "b103_13");
        expect_at(20, 1, 103, "d103_hold");
        load1(103);
        tick(25);

        // Retarget downward mid-animation, then a short count-up.
        load1(200);
        n = 0;
        while (dut1.disp_val_q !== 12'd110 && n < 100) begin
            tick(1);
            n++;
        end
        check_eq("reach110", int'(dut1.disp_val_q), 110);
        expect_at(1, 1, 50, "d50");
        expect_at(1, 2, 0, "b50");
        load1(50);
        expect_at(1, 2, 1, "b52_busy");
        expect_at(4, 1, 50, "d52_4");
        expect_at(5, 1, 51, "d52_5");
        expect_at(8, 2, 1, "b52_8");
        expect_at(9, 1, 52, "d52_9");
        expect_at(9, 2, 0, "b52_9");
        expect_at(20, 1, 52, "d52_hold");
        load1(52);
        tick(25);

        // Reset while animating and converting.
        load1(300);
        load0(1234);
        tick(4);
        reset_n = 1'b0;
        #1;
        reset_outputs_check("midrst");
        tick(3);
        reset_n = 1'b1;
        scan_check("post", 0, 0, 32);
        check_eq("post_busy1", int'(busy1), 0);
        check_eq("post_disp1", int'(dut1.disp_val_q), 0);
        check_eq("post_bcd0", int'(dut0.bcd_q), 0);

        check_eq("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/credit_display_mux.md
# credit_display_mux

Parametrised multiplexed seven-segment credit display for the slot machine FPGA. It takes credit values from the SPI data path and converts them to BCD with a sequential double-dabble engine. It then drives NUM_DIGITS common-anode/cathode digits through time-multiplexed digit selects, with leading-zero blanking, anti-ghosting blanking and an optional count-up animation. It sits beside the VGA/memory path in the top level and drives the `select` and `seven_segment_output` pins.

## Interface
- VALUE_WIDTH, 12: width of the credit value. Requires 10^NUM_DIGITS > 2^VALUE_WIDTH.
- NUM_DIGITS, 4: number of displayed digits. Digit 0 is least significant.
- REFRESH_DIV, 50000: clk cycles per digit slot. Must be ≥ 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all selects inactive. Must be < REFRESH_DIV.
- STEP_DIV, 250000: clk cycles per +1 step while animating. Must be ≥ 1.
- ANIMATE, 1: 1 = count up toward a larger target; 0 = jump immediately.
- SEG_ACTIVE_LOW, 1: segment outputs are active-low when 1.
- SEL_ACTIVE_LOW, 1: digit selects are active-low when 1.

Ports:
- clk  in  1  system clock. The only clock.
- reset_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  single-cycle strobe, synchronous to clk. Loads a new target.
- load_value  in  VALUE_WIDTH  new credit target, sampled when load_valid=1.
- busy  out  1  high while the displayed value is stepping toward the target.
- select  out  NUM_DIGITS  one-hot digit enable, polarity per SEL_ACTIVE_LOW.
- seven_segment_output  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.

## Operation
- Registers:
  - target: the latest loaded value.
  - disp_val: the value currently shown.
  - last_conv: the value held in the bcd register.
  - bcd: 4·NUM_DIGITS bits.
- Load: on load_valid, target <= load_value and the step counter clears. If ANIMATE=0 or load_value ≤ disp_val, disp_val <= load_value in the same update and busy=0. Otherwise busy=1.
- Animate: while disp_val < target, the step counter counts to STEP_DIV-1. On wrap, disp_val increments by 1. busy falls in the same cycle disp_val becomes equal to target.
- A load during animation retargets immediately. The lower-or-equal rule above applies against the current disp_val.
- The BCD engine is an FSM with two states, IDLE and CONV:
  - IDLE: if disp_val != last_conv, capture disp_val into the shift register, zero the BCD accumulator, set count=VALUE_WIDTH and go to CONV.
  - CONV: perform one add-3-then-shift iteration per cycle. On the last iteration, write bcd, set last_conv to the captured value and return to IDLE.
  - If disp_val changes during CONV, the current conversion completes, then IDLE restarts with the new value. The bcd register is never written with a partial result.
- Refresh: the slot counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances modulo NUM_DIGITS (wrap NUM_DIGITS-1 → 0).
  - Slot cycles 0..BLANK_CYCLES-1: all selects inactive, segments all off.
  - Remaining cycles: select[idx] active and segments show the decoded bcd nibble idx.
- Leading-zero blanking: digit idx > 0 is blanked (segments off, select still active) when it and all higher digits are 0. Digit 0 always shows, so the value 0 displays "0".
- Decode: 0–9 use the standard patterns; active-high 0 = 0111111, 1 = 0000110, … 9 = 1101111. Nibbles > 9 are impossible; decode them as all-off.
- Arithmetic: disp_val never exceeds target and never wraps. target is VALUE_WIDTH bits with no saturation logic needed.

## Timing
- Reset (asynchronous assert, synchronous release):
  - target, disp_val, last_conv and bcd = 0.
  - FSM = IDLE; counters = 0; idx = 0; busy = 0.
  - All selects inactive and all segments off.
- With ANIMATE=0, a load at cycle t makes disp_val valid at t+1. IDLE captures it at t+1, CONV runs t+2..t+1+VALUE_WIDTH, and bcd holds the new value from t+2+VALUE_WIDTH.
- The display shows the new digit on the next active portion of each slot after bcd updates. Worst-case visible latency is VALUE_WIDTH+2+NUM_DIGITS·REFRESH_DIV cycles.
- With animation, step k (k ≥ 1) lands at load cycle + k·STEP_DIV + 1.
- Outputs are registered; select and segments change only on clk edges.

## Test plan
Bench parameters: VALUE_WIDTH=12, NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, STEP_DIV=4, active-low polarities.

- Reset, no load → select=4'b1111 and segments=7'h7F during reset. Afterwards, slot 0 drives select=4'b1110 with segments=7'b1000000 ("0"), and slots 1–3 drive segments=7'h7F.
- ANIMATE=0, load 1234 → bcd=16'h1234 exactly 14 cycles after the strobe. The scan shows 4, 3, 2, 1 on select bits 0..3, and the first 2 cycles of every slot have select=4'b1111.
- ANIMATE=0, load 4095 then load 7 → digits show 5, 9, 0, 4, then only digit 0 lights "7" with digits 1–3 blanked. Also load 7 during CONV of 4095 → bcd goes 4095 then 7, never a mixed value.
- ANIMATE=1, displayed 100, load 103 → busy=1. disp_val reads 101/102/103 at strobe+5/+9/+13, and busy=0 at strobe+13.
- ANIMATE=1, animating 100→200, load 50 at disp_val=110 → disp_val=50 next cycle and busy=0. Then load 52 → steps 51, 52.
- reset_n low mid-animation and mid-CONV → all outputs are at reset values in the same cycle, with no glitch after release.
